axis_pulse_detect: RTL and testbench
====================================

AXIS_PULSE_DETECT -- requirements
Module: axis_pulse_detect

Interface
REQ-001 SHALL have parameter THRESHOLD, default 5000: signed pulse-entry level per 16-bit sample.
REQ-002 SHALL have parameter HYST, default 500: exit level is THRESHOLD-HYST.
REQ-003 SHALL have parameter MIN_WIDTH, default 2: pulses shorter than this many beats are discarded.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2: number of result records buffered.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock.
REQ-006 SHALL have port aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port s_axis_tdata, input, 32 bits: two signed ADC samples; [15:0] is earlier, [31:16] is later.
REQ-008 SHALL have port s_axis_tvalid, input, 1 bit: ADC beat valid.
REQ-009 SHALL have port s_axis_tready, output, 1 bit: always high outside reset; the ADC is never stalled.
REQ-010 SHALL have port m_axis_tdata, output, 64 bits: result record {peak[63:48], width[47:32], start_ts[31:0]}.
REQ-011 SHALL have port m_axis_tvalid, output, 1 bit: record valid.
REQ-012 SHALL have port m_axis_tready, input, 1 bit: downstream ready.
REQ-013 SHALL have port pulse_active, output, 1 bit: high while the FSM is in HIGH.
REQ-014 SHALL have port drop_cnt, output, 16 bits: records lost to a full FIFO; saturates at 0xFFFF.

Function
REQ-015 SHALL accept a beat when s_axis_tvalid=1; cycles with tvalid=0 SHALL leave all state and counters unchanged.
REQ-016 SHALL keep a 32-bit timestamp counter ts: the first accepted beat after reset has ts=0, incrementing per beat and wrapping 0xFFFFFFFF->0.
REQ-017 SHALL compare samples signed: "above" if either sample >= THRESHOLD; "below" if both samples < THRESHOLD-HYST.
REQ-018 SHALL implement FSM IDLE/HIGH; IDLE->HIGH on an "above" beat, latching start_ts=ts of that beat and width=1.
REQ-019 SHALL, in HIGH, increment width per non-"below" beat, saturating at 0xFFFF while staying in HIGH.
REQ-020 SHALL, in HIGH, go to IDLE on a "below" beat, which is not counted in width.
REQ-021 SHALL, on that exit, push the record if width >= MIN_WIDTH and drop it silently otherwise (drop_cnt unchanged).
REQ-022 SHALL raise m_axis_tvalid on the cycle after the exit beat (latency 1) when the FIFO was empty.
REQ-023 SHALL hold m_axis_tdata stable while tvalid=1 and tready=0; records are popped on tvalid&tready, in order.
REQ-024 SHALL, on a push with the FIFO full and no pop that cycle, discard the new record and increment drop_cnt.
REQ-025 SHALL, on a push and pop in the same cycle with the FIFO full, accept the push with no drop.
REQ-026 SHALL allow an exit beat to be immediately followed by an "above" beat, restarting HIGH on the next beat.

Reset
REQ-027 SHALL, while aresetn=0 at a rising aclk edge, set: FSM=IDLE, ts=0, width=0, FIFO empty, m_axis_tvalid=0, m_axis_tdata=0, pulse_active=0, drop_cnt=0, s_axis_tready=0.
REQ-028 SHALL discard a pulse in progress at reset without emitting a record.

Configuration
REQ-029 SHALL, with macro PULSE_DETECT_PEAK_EN defined, track the maximum signed sample over all counted beats of a pulse into the peak field.
REQ-030 SHALL, without PULSE_DETECT_PEAK_EN, tie the peak field to 0 and omit the peak logic.

Verification
REQ-031 SHALL cover: beats 0,0,{6000,0},{5200,5200},{100,100} with tready=1 -> one record width=2, start_ts=2, peak=6000 (PEAK_EN), tvalid 1 cycle after the exit beat.
REQ-032 SHALL cover: single beat {7000,0} then {0,0} -> no record (width 1 < MIN_WIDTH).
REQ-033 SHALL cover: hysteresis, with samples 6000,4800,4600,4400 (one per beat, the other sample 0) -> stays HIGH through 4600; exits at 4400; width=3.
REQ-034 SHALL cover: tready=0 during three qualifying pulses -> first two records retained in order; drop_cnt=1; records drain correctly when tready goes to 1.
REQ-035 SHALL cover: tvalid gaps inserted inside a pulse -> width and ts unaffected by gap cycles.
REQ-036 SHALL cover: aresetn pulsed low mid-pulse -> no record, pulse_active=0, and the next beat has ts=0.

Source files
------------

// File: rtl/axis_pulse_detect.sv
// Threshold/hysteresis pulse detector on a 2-sample-per-beat AXI-Stream ADC feed, emitting
// {peak, width, start_ts} records through a small FIFO. Define PULSE_DETECT_PEAK_EN to track peak.
module axis_pulse_detect #(
    parameter int THRESHOLD  = 5000,
    parameter int HYST       = 500,
    parameter int MIN_WIDTH  = 2,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        pulse_active,
    output logic [15:0] drop_cnt
);

    localparam int                 CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic signed [31:0] ENTRY_LVL = 32'(THRESHOLD);
    localparam logic signed [31:0] EXIT_LVL  = 32'(THRESHOLD - HYST);
    localparam logic [15:0]        MIN_W16   = 16'(MIN_WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        ts_q, ts_d;
    logic [31:0]        start_ts_q, start_ts_d;
    logic [15:0]        width_q, width_d;
    logic               tready_q;
    logic               pulse_active_q;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               m_valid_q;
    logic [63:0]        mem_q [FIFO_DEPTH];
    logic [63:0]        mem_d [FIFO_DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;

    logic signed [31:0] lo_ext_s, hi_ext_s;
    logic signed [15:0] beat_max_s;
    logic               above_s, below_s, accept_s;
    logic               push_s, pop_s, full_s, wr_en_s, drop_s;
    logic [CNT_W-1:0]   wr_idx_s;
    logic [15:0]        peak_field_s;
    logic [63:0]        rec_s;

    assign lo_ext_s   = {{16{s_axis_tdata[15]}}, s_axis_tdata[15:0]};
    assign hi_ext_s   = {{16{s_axis_tdata[31]}}, s_axis_tdata[31:16]};
    assign beat_max_s = (hi_ext_s > lo_ext_s) ? s_axis_tdata[31:16] : s_axis_tdata[15:0];
    assign above_s    = (lo_ext_s >= ENTRY_LVL) || (hi_ext_s >= ENTRY_LVL);
    assign below_s    = (lo_ext_s < EXIT_LVL) && (hi_ext_s < EXIT_LVL);
    assign accept_s   = s_axis_tvalid && tready_q;

`ifdef PULSE_DETECT_PEAK_EN
    logic signed [15:0] peak_q, peak_d;

    // Peak register follows the largest sample of every counted beat.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            peak_q <= 16'sd0;
        end else begin
            peak_q <= peak_d;
        end
    end

    // Peak next-state: seed on entry, raise on larger counted samples.
    always_comb begin
        peak_d = peak_q;
        if (accept_s && (state_q == ST_IDLE) && above_s) begin
            peak_d = beat_max_s;
        end else if (accept_s && (state_q == ST_HIGH) && !below_s && (beat_max_s > peak_q)) begin
            peak_d = beat_max_s;
        end else begin
            peak_d = peak_q;
        end
    end

    assign peak_field_s = peak_q;
`else
    assign peak_field_s = 16'd0;
`endif

    assign rec_s = {peak_field_s, width_q, start_ts_q};

    // Pulse FSM next-state, timestamp and width accounting.
    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q;
        start_ts_d = start_ts_q;
        width_d    = width_q;
        push_s     = 1'b0;
        if (accept_s) begin
            ts_d = ts_q + 32'd1;
            case (state_q)
                ST_IDLE: begin
                    if (above_s) begin
                        state_d    = ST_HIGH;
                        start_ts_d = ts_q;
                        width_d    = 16'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (below_s) begin
                        state_d = ST_IDLE;
                        push_s  = (width_q >= MIN_W16);
                    end else if (width_q != 16'hFFFF) begin
                        width_d = width_q + 16'd1;
                    end else begin
                        width_d = width_q;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            ts_d = ts_q;
        end
    end

    assign full_s   = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_s    = m_valid_q && m_axis_tready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    assign wr_en_s  = push_s && (!full_s || pop_s);
    assign drop_s   = push_s && full_s && !pop_s;
    assign wr_idx_s = pop_s ? (count_q - CNT_W'(1)) : count_q;

    // Shift-register FIFO: slot 0 is always the head, so the output is a plain register.
    always_comb begin
        mem_d = mem_q;
        if (pop_s) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                mem_d[i] = mem_q[i+1];
            end
            mem_d[FIFO_DEPTH-1] = 64'd0;
        end else begin
            mem_d = mem_q;
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_en_s && (wr_idx_s == CNT_W'(i))) begin
                mem_d[i] = rec_s;
            end else begin
                mem_d[i] = mem_d[i];
            end
        end
        count_d = count_q + CNT_W'(wr_en_s) - CNT_W'(pop_s);
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State, counters and FIFO registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            ts_q           <= 32'd0;
            start_ts_q     <= 32'd0;
            width_q        <= 16'd0;
            tready_q       <= 1'b0;
            pulse_active_q <= 1'b0;
            drop_cnt_q     <= 16'd0;
            m_valid_q      <= 1'b0;
            count_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else begin
            state_q        <= state_d;
            ts_q           <= ts_d;
            start_ts_q     <= start_ts_d;
            width_q        <= width_d;
            tready_q       <= 1'b1;
            pulse_active_q <= (state_d == ST_HIGH);
            drop_cnt_q     <= drop_cnt_d;
            m_valid_q      <= (count_d != '0);
            count_q        <= count_d;
            mem_q          <= mem_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = mem_q[0];
    assign m_axis_tvalid = m_valid_q;
    assign pulse_active  = pulse_active_q;
    assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_axis_pulse_detect.sv
// Self-checking bench for axis_pulse_detect: directed scenarios plus a randomized run
// compared against a beat-list reference model.
module tb_axis_pulse_detect;

    localparam int TH    = 5000;
    localparam int HY    = 500;
    localparam int MINW  = 2;
    localparam int DEPTH = 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axis_tdata = 32'd0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        pulse_active;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: a pulse is the list of its counted beats.
    logic [31:0] m_ts;
    bit          m_in;
    bit          m_rdy;
    logic [31:0] m_start;
    int          m_beats[$];
    logic [63:0] m_fifo[$];
    int          m_drop;

    axis_pulse_detect #(
        .THRESHOLD (TH),
        .HYST      (HY),
        .MIN_WIDTH (MINW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .pulse_active (pulse_active),
        .drop_cnt     (drop_cnt)
    );

    always #5 aclk = ~aclk;

    function automatic logic [63:0] mk_rec(input int peak, input int width, input int start);
        logic [15:0] p;
`ifdef PULSE_DETECT_PEAK_EN
        p = 16'(peak);
`else
        p = 16'd0;
`endif
        return {p, 16'(width), 32'(start)};
    endfunction

    task automatic model_edge(input bit rst_n, input bit v, input logic [31:0] d, input bit rdy);
        int s0, s1, bmax, w, pmax;
        logic [63:0] tmp;
        if (!rst_n) begin
            m_ts = 32'd0; m_in = 1'b0; m_rdy = 1'b0; m_drop = 0;
            m_beats.delete(); m_fifo.delete();
            return;
        end
        if (m_fifo.size() > 0 && rdy) tmp = m_fifo.pop_front();
        if (v && m_rdy) begin
            s0 = int'($signed(d[15:0]));
            s1 = int'($signed(d[31:16]));
            bmax = (s0 > s1) ? s0 : s1;
            if (!m_in) begin
                if (s0 >= TH || s1 >= TH) begin
                    m_in = 1'b1; m_start = m_ts;
                    m_beats.delete(); m_beats.push_back(bmax);
                end
            end else if (s0 < TH - HY && s1 < TH - HY) begin
                m_in = 1'b0;
                w = (m_beats.size() > 65535) ? 65535 : m_beats.size();
                if (w >= MINW) begin
                    pmax = m_beats[0];
                    foreach (m_beats[i]) if (m_beats[i] > pmax) pmax = m_beats[i];
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(mk_rec(pmax, w, int'(m_start)));
                    else if (m_drop < 65535) m_drop++;
                end
            end else begin
                m_beats.push_back(bmax);
            end
            m_ts = m_ts + 32'd1;
        end
        m_rdy = 1'b1;
    endtask

    // One clock: drive at negedge, model at posedge, return at next negedge.
    task automatic cyc(input bit v, input logic signed [15:0] a, input logic signed [15:0] b, input bit rdy);
        s_axis_tvalid = v;
        s_axis_tdata  = {b, a};
        m_axis_tready = rdy;
        @(posedge aclk);
        model_edge(aresetn, v, {b, a}, rdy);
        @(negedge aclk);
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        repeat (3) cyc(1'b0, 16'sd0, 16'sd0, 1'b0);
        aresetn = 1'b1;
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        cyc(1'b1, 16'sd7000, 16'sd7000, 1'b0);
        cyc(1'b1, 16'sd7000, 16'sd7000, 1'b0);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b exp 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 64'd0) begin errors++; $display("FAIL reset_tdata: got %h exp 0", m_axis_tdata); end
        checks++; if (pulse_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b exp 0", pulse_active); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop: got %0d exp 0", drop_cnt); end
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b exp 0", s_axis_tready); end
        aresetn = 1'b1;
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL tready_after_reset: got %b exp 1", s_axis_tready); end
    endtask

    task automatic test_basic();
        apply_reset();
        cyc(1'b1, 16'sd0, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd0, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd6000, 16'sd0, 1'b1);
        checks++; if (pulse_active !== 1'b1) begin errors++; $display("FAIL basic_active: got %b exp 1", pulse_active); end
        cyc(1'b1, 16'sd5200, 16'sd5200, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b exp 0", m_axis_tvalid); end
        cyc(1'b1, 16'sd100, 16'sd100, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== mk_rec(6000, 2, 2)) begin errors++; $display("FAIL basic_rec: got %h exp %h", m_axis_tdata, mk_rec(6000, 2, 2)); end
        checks++; if (pulse_active !== 1'b0) begin errors++; $display("FAIL basic_exit: got %b exp 0", pulse_active); end
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_pop: got %b exp 0", m_axis_tvalid); end
    endtask

    task automatic test_short();
        apply_reset();
        cyc(1'b1, 16'sd7000, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd0, 16'sd0, 1'b1);
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL short_valid: got %b exp 0", m_axis_tvalid); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL short_drop: got %0d exp 0", drop_cnt); end
    endtask

    task automatic test_hyst();
        apply_reset();
        cyc(1'b1, 16'sd6000, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd4800, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd4600, 16'sd0, 1'b1);
        checks++; if (pulse_active !== 1'b1) begin errors++; $display("FAIL hyst_hold: got %b exp 1", pulse_active); end
        cyc(1'b1, 16'sd4400, 16'sd0, 1'b1);
        checks++; if (pulse_active !== 1'b0) begin errors++; $display("FAIL hyst_exit: got %b exp 0", pulse_active); end
        checks++; if (m_axis_tdata !== mk_rec(6000, 3, 0) || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL hyst_rec: got %b/%h exp 1/%h", m_axis_tvalid, m_axis_tdata, mk_rec(6000, 3, 0)); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            cyc(1'b1, 16'sd6000, 16'sd0, 1'b0);
            cyc(1'b1, 16'sd0, 16'sd6100, 1'b0);
            cyc(1'b1, 16'sd0, 16'sd0, 1'b0);
        end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL full_drop: got %0d exp 1", drop_cnt); end
        checks++; if (m_axis_tdata !== mk_rec(6100, 2, 0) || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL full_head_hold: got %b/%h exp 1/%h", m_axis_tvalid, m_axis_tdata, mk_rec(6100, 2, 0)); end
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        checks++; if (m_axis_tdata !== mk_rec(6100, 2, 3) || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL full_second: got %b/%h exp 1/%h", m_axis_tvalid, m_axis_tdata, mk_rec(6100, 2, 3)); end
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b exp 0", m_axis_tvalid); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL full_drop_hold: got %0d exp 1", drop_cnt); end
    endtask

    task automatic test_gaps();
        apply_reset();
        cyc(1'b1, 16'sd6000, 16'sd0, 1'b1);
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd5000, 16'sd0, 1'b1);
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd0, 16'sd0, 1'b1);
        checks++; if (m_axis_tdata !== mk_rec(6000, 2, 0) || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL gaps_rec: got %b/%h exp 1/%h", m_axis_tvalid, m_axis_tdata, mk_rec(6000, 2, 0)); end
        cyc(1'b1, 16'sd6500, 16'sd0, 1'b1);
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd6000, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd0, 16'sd0, 1'b1);
        checks++; if (m_axis_tdata !== mk_rec(6500, 2, 3) || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL gaps_ts: got %b/%h exp 1/%h", m_axis_tvalid, m_axis_tdata, mk_rec(6500, 2, 3)); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        cyc(1'b1, 16'sd6000, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd6000, 16'sd0, 1'b1);
        aresetn = 1'b0;
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        aresetn = 1'b1;
        cyc(1'b0, 16'sd0, 16'sd0, 1'b1);
        checks++; if (pulse_active !== 1'b0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_state: got %b/%b exp 0/0", pulse_active, m_axis_tvalid); end
        cyc(1'b1, 16'sd7000, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd7000, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd0, 16'sd0, 1'b1);
        checks++; if (m_axis_tdata !== mk_rec(7000, 2, 0) || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rstmid_ts: got %b/%h exp 1/%h", m_axis_tvalid, m_axis_tdata, mk_rec(7000, 2, 0)); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        cyc(1'b1, 16'sd6000, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd6000, 16'sd0, 1'b1);
        cyc(1'b1, -16'sd200, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd0, 16'sd5600, 1'b1);
        checks++; if (pulse_active !== 1'b1) begin errors++; $display("FAIL b2b_restart: got %b exp 1", pulse_active); end
        cyc(1'b1, 16'sd5100, 16'sd0, 1'b1);
        cyc(1'b1, 16'sd0, 16'sd0, 1'b1);
        checks++; if (m_axis_tdata !== mk_rec(5600, 2, 3) || m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL b2b_rec: got %b/%h exp 1/%h", m_axis_tvalid, m_axis_tdata, mk_rec(5600, 2, 3)); end
    endtask

    function automatic logic [15:0] rsamp();
        case ($urandom_range(0, 3))
            0: return 16'($urandom_range(5000, 8000));
            1: return 16'($urandom_range(4300, 5100));
            2: return 16'($urandom_range(0, 4400));
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic test_random();
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            checks++; if (m_axis_tvalid !== (m_fifo.size() > 0)) begin errors++; $display("FAIL rnd_valid @%0d: got %b exp %b", n, m_axis_tvalid, m_fifo.size() > 0); end
            if (m_fifo.size() > 0) begin
                checks++; if (m_axis_tdata !== m_fifo[0]) begin errors++; $display("FAIL rnd_data @%0d: got %h exp %h", n, m_axis_tdata, m_fifo[0]); end
            end
            checks++; if (pulse_active !== m_in) begin errors++; $display("FAIL rnd_active @%0d: got %b exp %b", n, pulse_active, m_in); end
            checks++; if (drop_cnt !== 16'(m_drop)) begin errors++; $display("FAIL rnd_drop @%0d: got %0d exp %0d", n, drop_cnt, m_drop); end
            cyc($urandom_range(0, 9) < 8, rsamp(), rsamp(), $urandom_range(0, 99) < 40);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_hyst();
        test_full();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
